// File: rtl/cpu_acumulador_param_if.sv
// Operand, program-load and observation signals of the accumulator CPU.
// Clock and reset stay outside the interface as plain ports.
interface cpu_acumulador_param_if #(
  parameter int LARGURA = 8,
  parameter int PROF    = 16
);
  localparam int AW = $clog2(PROF);

  logic [LARGURA-1:0] entrada;
  logic               iniciar;
  logic               prog_we;
  logic [AW-1:0]      prog_addr;
  logic [3+LARGURA:0] prog_dado;

  logic [LARGURA-1:0] saida;
  logic               saida_valida;
  logic [LARGURA-1:0] acumulador;
  logic [LARGURA-1:0] barramento;
  logic [1:0]         etapa;
  logic [AW-1:0]      pc;
  logic               carry;
  logic               zero;
  logic               parado;

  // iniciar and prog_we are level requests sampled on the rising edge;
  // they take effect only while parado is high, otherwise they are dropped.
  modport slave (
    input  entrada, iniciar, prog_we, prog_addr, prog_dado,
    output saida, saida_valida, acumulador, barramento, etapa, pc,
           carry, zero, parado
  );

  modport master (
    output entrada, iniciar, prog_we, prog_addr, prog_dado,
    input  saida, saida_valida, acumulador, barramento, etapa, pc,
           carry, zero, parado
  );
endinterface

// File: rtl/cpu_acumulador_param.sv
// Accumulator CPU: X/Y/Z registers and ALU sequenced by a three-step
// fetch/decode/execute machine from a writable program memory.
module cpu_acumulador_param #(
  parameter int LARGURA = 8,
  parameter int PROF    = 16
) (
  input logic                   clock,
  input logic                   reset_n,
  cpu_acumulador_param_if.slave bus
);
  localparam int AW = $clog2(PROF);

  localparam logic [3:0] OP_CARREGA_X   = 4'h1;
  localparam logic [3:0] OP_CARREGA_IMM = 4'h2;
  localparam logic [3:0] OP_SOMA        = 4'h3;
  localparam logic [3:0] OP_SUB         = 4'h4;
  localparam logic [3:0] OP_E           = 4'h5;
  localparam logic [3:0] OP_OU          = 4'h6;
  localparam logic [3:0] OP_NAO         = 4'h7;
  localparam logic [3:0] OP_LIMPA       = 4'h8;
  localparam logic [3:0] OP_SAIDA       = 4'h9;
  localparam logic [3:0] OP_JZ          = 4'hA;
  localparam logic [3:0] OP_JMP         = 4'hB;
  localparam logic [3:0] OP_CARREGA_Y   = 4'hC;
  localparam logic [3:0] OP_HALT        = 4'hF;

  typedef enum logic [1:0] {
    PARADO     = 2'd0,
    BUSCA      = 2'd1,
    DECODIFICA = 2'd2,
    EXECUTA    = 2'd3
  } etapa_t;

  etapa_t             r_etapa, w_etapa_next;
  logic [AW-1:0]      r_pc, w_pc_next;
  logic [3+LARGURA:0] r_ir, w_ir_next;
  logic [LARGURA-1:0] r_x, w_x_next;
  logic [LARGURA-1:0] r_y, w_y_next;
  logic [LARGURA-1:0] r_z, w_z_next;
  logic               r_carry, w_carry_next;
  logic               r_zero, w_zero_next;
  logic               r_valida, w_valida_next;
  logic               w_y_upd;

  logic [3+LARGURA:0] r_mem [PROF];

  logic [3:0]         w_op;
  logic [LARGURA-1:0] w_imm;
  logic [AW-1:0]      w_alvo;
  logic [LARGURA:0]   w_soma;
  logic [LARGURA:0]   w_dif;

  assign w_op   = r_ir[3+LARGURA -: 4];
  assign w_imm  = r_ir[LARGURA-1:0];
  assign w_alvo = AW'(w_imm);
  // The extra top bit is the carry for SOMA and the borrow (Y<X) for SUB.
  assign w_soma = {1'b0, r_y} + {1'b0, r_x};
  assign w_dif  = {1'b0, r_y} - {1'b0, r_x};

  always_ff @(posedge clock) begin
    if (!reset_n) r_etapa <= PARADO;
    else          r_etapa <= w_etapa_next;
  end

  always_comb begin
    w_etapa_next  = r_etapa;
    w_pc_next     = r_pc;
    w_ir_next     = r_ir;
    w_x_next      = r_x;
    w_y_next      = r_y;
    w_z_next      = r_z;
    w_carry_next  = r_carry;
    w_zero_next   = r_zero;
    w_valida_next = 1'b0;
    w_y_upd       = 1'b0;
    case (r_etapa)
      PARADO: begin
        if (bus.iniciar) begin
          w_pc_next    = '0;
          w_etapa_next = BUSCA;
        end
      end
      BUSCA: begin
        w_ir_next    = r_mem[r_pc];
        w_pc_next    = r_pc + AW'(1);
        w_etapa_next = DECODIFICA;
      end
      DECODIFICA: begin
        if (w_op == OP_CARREGA_X)   w_x_next = bus.entrada;
        if (w_op == OP_CARREGA_IMM) w_x_next = w_imm;
        w_etapa_next = EXECUTA;
      end
      EXECUTA: begin
        w_etapa_next = BUSCA;
        case (w_op)
          OP_SOMA: begin
            w_y_next     = w_soma[LARGURA-1:0];
            w_carry_next = w_soma[LARGURA];
            w_y_upd      = 1'b1;
          end
          OP_SUB: begin
            w_y_next     = w_dif[LARGURA-1:0];
            w_carry_next = w_dif[LARGURA];
            w_y_upd      = 1'b1;
          end
          OP_E:         begin w_y_next = r_y & r_x; w_carry_next = 1'b0; w_y_upd = 1'b1; end
          OP_OU:        begin w_y_next = r_y | r_x; w_carry_next = 1'b0; w_y_upd = 1'b1; end
          OP_NAO:       begin w_y_next = ~r_y;      w_carry_next = 1'b0; w_y_upd = 1'b1; end
          OP_LIMPA:     begin w_y_next = '0;        w_carry_next = 1'b0; w_y_upd = 1'b1; end
          OP_CARREGA_Y: begin w_y_next = r_x;       w_carry_next = 1'b0; w_y_upd = 1'b1; end
          OP_SAIDA: begin
            w_z_next      = r_y;
            w_valida_next = 1'b1;
          end
          // A taken jump overrides the pc already advanced during BUSCA.
          OP_JZ:   if (r_y == '0) w_pc_next = w_alvo;
          OP_JMP:  w_pc_next = w_alvo;
          OP_HALT: w_etapa_next = PARADO;
          default: ;
        endcase
        if (w_y_upd) w_zero_next = (w_y_next == '0);
      end
      default: w_etapa_next = PARADO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_pc     <= '0;
      r_ir     <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_z      <= '0;
      r_carry  <= 1'b0;
      r_zero   <= 1'b1;
      r_valida <= 1'b0;
    end else begin
      r_pc     <= w_pc_next;
      r_ir     <= w_ir_next;
      r_x      <= w_x_next;
      r_y      <= w_y_next;
      r_z      <= w_z_next;
      r_carry  <= w_carry_next;
      r_zero   <= w_zero_next;
      r_valida <= w_valida_next;
    end
  end

  // Program memory has no reset; loads are accepted only while stopped.
  always_ff @(posedge clock) begin
    if (reset_n && (r_etapa == PARADO) && bus.prog_we)
      r_mem[bus.prog_addr] <= bus.prog_dado;
  end

  assign bus.saida        = r_z;
  assign bus.saida_valida = r_valida;
  assign bus.acumulador   = r_y;
  assign bus.barramento   = r_x;
  assign bus.etapa        = r_etapa;
  assign bus.pc           = r_pc;
  assign bus.carry        = r_carry;
  assign bus.zero         = r_zero;
  assign bus.parado       = (r_etapa == PARADO);
endmodule

// File: tb/tb_cpu_acumulador_param.sv
// Directed bench for cpu_acumulador_param (LARGURA=8, PROF=16): loads small
// programs, runs them and checks registers, flags, pulse timing and pc flow.
module tb_cpu_acumulador_param;
  localparam int LARGURA = 8;
  localparam int PROF    = 16;
  localparam int AW      = 4;

  logic clock = 1'b0;
  logic reset_n = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [AW-1:0] fetch_q[$];
  logic [AW-1:0] exp_q[$];
  int            pulse_q[$];
  int            exp_pulse_q[$];

  cpu_acumulador_param_if #(.LARGURA(LARGURA), .PROF(PROF)) bus();

  cpu_acumulador_param #(.LARGURA(LARGURA), .PROF(PROF)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.entrada   = 8'($urandom_range(0, 255));
    bus.iniciar   = 1'($urandom_range(0, 1));
    bus.prog_we   = 1'b0;
    bus.prog_addr = 4'($urandom_range(0, 15));
    bus.prog_dado = 12'($urandom_range(0, 4095));
    tick();
    tick();
    bus.iniciar = 1'b0;
    bus.prog_we = 1'b0;
    reset_n = 1'b1;
  endtask

  task automatic load(input int addr, input logic [3:0] op, input logic [7:0] imm);
    bus.prog_we   = 1'b1;
    bus.prog_addr = addr[3:0];
    bus.prog_dado = {op, imm};
    tick();
    bus.prog_we = 1'b0;
  endtask

  // Starts the program and follows it until parado or the cycle budget runs
  // out. Cycle 0 is the first BUSCA. disturb pulses iniciar/prog_we mid-run.
  task automatic run_prog(input int budget, input bit disturb, output int halt_cyc);
    fetch_q.delete();
    pulse_q.delete();
    halt_cyc = -1;
    bus.iniciar = 1'b1;
    tick();
    bus.iniciar = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (bus.etapa == 2'd1) fetch_q.push_back(bus.pc);
      if (bus.saida_valida) pulse_q.push_back(k);
      if (bus.parado) begin
        halt_cyc = k;
        break;
      end
      if (disturb && k >= 1 && k <= 5) begin
        bus.iniciar   = 1'b1;
        bus.prog_we   = 1'b1;
        bus.prog_addr = 4'd2;
        bus.prog_dado = 12'hF00;
      end else begin
        bus.iniciar = 1'b0;
        bus.prog_we = 1'b0;
      end
      tick();
    end
    bus.iniciar = 1'b0;
    bus.prog_we = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.entrada   = 8'($urandom_range(0, 255));
    bus.iniciar   = 1'($urandom_range(0, 1));
    bus.prog_we   = 1'($urandom_range(0, 1));
    bus.prog_addr = 4'($urandom_range(0, 15));
    bus.prog_dado = 12'($urandom_range(0, 4095));
    tick();
    tick();
    n_tests++;
    if ({bus.etapa, bus.parado, bus.pc} !== {2'd0, 1'b1, 4'd0}) begin
      n_fail++;
      $display("FAIL reset_state etapa/parado/pc got %h/%b/%h exp 0/1/0", bus.etapa, bus.parado, bus.pc);
    end
    n_tests++;
    if ({bus.saida, bus.acumulador, bus.barramento} !== 24'h000000) begin
      n_fail++;
      $display("FAIL reset_regs z/y/x got %h/%h/%h exp 00/00/00", bus.saida, bus.acumulador, bus.barramento);
    end
    n_tests++;
    if ({bus.carry, bus.zero, bus.saida_valida} !== 3'b010) begin
      n_fail++;
      $display("FAIL reset_flags carry/zero/valida got %b%b%b exp 010", bus.carry, bus.zero, bus.saida_valida);
    end
    bus.iniciar = 1'b0;
    bus.prog_we = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    n_tests++;
    if ({bus.etapa, bus.pc} !== {2'd0, 4'd0}) begin
      n_fail++;
      $display("FAIL idle_after_reset etapa/pc got %h/%h exp 0/0", bus.etapa, bus.pc);
    end
  endtask

  task automatic test_add_output();
    int h;
    load(0, 4'h2, 8'h2A);
    load(1, 4'hC, 8'h00);
    load(2, 4'h1, 8'h00);
    load(3, 4'h3, 8'h00);
    load(4, 4'h9, 8'h00);
    load(5, 4'hF, 8'h00);
    bus.entrada = 8'h15;
    run_prog(100, 1'b0, h);
    n_tests++;
    if (h !== 18) begin n_fail++; $display("FAIL add_halt_cycle got %0d exp 18", h); end
    n_tests++;
    if ({bus.saida, bus.acumulador, bus.barramento} !== 24'h3F3F15) begin
      n_fail++;
      $display("FAIL add_regs z/y/x got %h/%h/%h exp 3f/3f/15", bus.saida, bus.acumulador, bus.barramento);
    end
    n_tests++;
    if ({bus.carry, bus.zero} !== 2'b00) begin
      n_fail++; $display("FAIL add_flags carry/zero got %b%b exp 00", bus.carry, bus.zero);
    end
    n_tests++;
    if (pulse_q.size() !== 1 || pulse_q[0] !== 15) begin
      n_fail++; $display("FAIL add_valida_pulse count %0d first %0d exp 1 at 15", pulse_q.size(), (pulse_q.size() > 0) ? pulse_q[0] : -1);
    end
  endtask

  task automatic test_overflow();
    int h;
    load(0, 4'h2, 8'hFF);
    load(1, 4'hC, 8'h00);
    load(2, 4'h2, 8'h01);
    load(3, 4'h3, 8'h00);
    load(4, 4'hF, 8'h00);
    run_prog(100, 1'b0, h);
    n_tests++;
    if ({h[7:0], bus.acumulador, bus.carry, bus.zero} !== {8'd15, 8'h00, 2'b11}) begin
      n_fail++;
      $display("FAIL overflow halt/y/carry/zero got %0d/%h/%b/%b exp 15/00/1/1", h, bus.acumulador, bus.carry, bus.zero);
    end
    load(0, 4'h8, 8'h00);
    load(1, 4'hF, 8'h00);
    run_prog(100, 1'b0, h);
    n_tests++;
    if ({bus.acumulador, bus.carry, bus.zero} !== {8'h00, 2'b01}) begin
      n_fail++;
      $display("FAIL limpa_clears_carry y/carry/zero got %h/%b/%b exp 00/0/1", bus.acumulador, bus.carry, bus.zero);
    end
    load(0, 4'h8, 8'h00);
    load(1, 4'h2, 8'h01);
    load(2, 4'h4, 8'h00);
    load(3, 4'hF, 8'h00);
    run_prog(100, 1'b0, h);
    n_tests++;
    if ({h[7:0], bus.acumulador, bus.carry, bus.zero} !== {8'd12, 8'hFF, 2'b10}) begin
      n_fail++;
      $display("FAIL borrow halt/y/carry/zero got %0d/%h/%b/%b exp 12/ff/1/0", h, bus.acumulador, bus.carry, bus.zero);
    end
  endtask

  task automatic test_logic();
    int h;
    load(0, 4'h2, 8'h0F);
    load(1, 4'hC, 8'h00);
    load(2, 4'h2, 8'h3C);
    load(3, 4'h5, 8'h00);
    load(4, 4'h6, 8'h00);
    load(5, 4'h7, 8'h00);
    load(6, 4'h9, 8'h00);
    load(7, 4'hF, 8'h00);
    run_prog(100, 1'b0, h);
    n_tests++;
    if ({h[7:0], bus.saida, bus.carry, bus.zero} !== {8'd24, 8'hC3, 2'b00}) begin
      n_fail++;
      $display("FAIL logic halt/z/carry/zero got %0d/%h/%b/%b exp 24/c3/0/0", h, bus.saida, bus.carry, bus.zero);
    end
    n_tests++;
    if (pulse_q.size() !== 1 || pulse_q[0] !== 21) begin
      n_fail++; $display("FAIL logic_pulse count %0d first %0d exp 1 at 21", pulse_q.size(), (pulse_q.size() > 0) ? pulse_q[0] : -1);
    end
  endtask

  task automatic test_back_to_back();
    int h;
    load(0, 4'h9, 8'h00);
    load(1, 4'h9, 8'h00);
    load(2, 4'hF, 8'h00);
    run_prog(100, 1'b0, h);
    exp_pulse_q = '{3, 6};
    n_tests++;
    if (h !== 9 || pulse_q.size() !== exp_pulse_q.size()) begin
      n_fail++; $display("FAIL b2b_halt_count halt %0d pulses %0d exp 9 and 2", h, pulse_q.size());
    end else begin
      for (int i = 0; i < exp_pulse_q.size(); i++) begin
        n_tests++;
        if (pulse_q[i] !== exp_pulse_q[i]) begin
          n_fail++; $display("FAIL b2b_pulse%0d got cycle %0d exp %0d", i, pulse_q[i], exp_pulse_q[i]);
        end
      end
    end
  endtask

  task automatic test_loop();
    int h;
    load(0, 4'h2, 8'h03);
    load(1, 4'hC, 8'h00);
    load(2, 4'h2, 8'h01);
    load(3, 4'h4, 8'h00);
    load(4, 4'hA, 8'h06);
    load(5, 4'hB, 8'h03);
    load(6, 4'h9, 8'h00);
    load(7, 4'hF, 8'h00);
    run_prog(200, 1'b0, h);
    exp_q = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd3, 4'd4, 4'd5, 4'd3, 4'd4, 4'd6, 4'd7};
    n_tests++;
    if ({h[7:0], bus.pc, bus.saida, bus.zero, bus.carry} !== {8'd39, 4'd8, 8'h00, 2'b10}) begin
      n_fail++;
      $display("FAIL loop halt/pc/z/zero/carry got %0d/%h/%h/%b/%b exp 39/8/00/1/0", h, bus.pc, bus.saida, bus.zero, bus.carry);
    end
    n_tests++;
    if (fetch_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL loop_fetch_count got %0d exp %0d", fetch_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_tests++;
        if (fetch_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL loop_fetch%0d got %h exp %h", i, fetch_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_protection();
    int h;
    load(0, 4'h2, 8'h05);
    load(1, 4'hC, 8'h00);
    load(2, 4'h9, 8'h00);
    load(3, 4'hF, 8'h00);
    run_prog(100, 1'b1, h);
    n_tests++;
    if ({h[7:0], bus.saida} !== {8'd12, 8'h05} || pulse_q.size() !== 1) begin
      n_fail++; $display("FAIL protect_run halt/z/pulses got %0d/%h/%0d exp 12/05/1", h, bus.saida, pulse_q.size());
    end
    run_prog(100, 1'b0, h);
    n_tests++;
    if (h !== 12 || pulse_q.size() !== 1) begin
      n_fail++; $display("FAIL protect_mem halt/pulses got %0d/%0d exp 12/1", h, pulse_q.size());
    end
    load(0, 4'h1, 8'h00);
    load(1, 4'hF, 8'h00);
    bus.entrada = 8'h77;
    bus.iniciar = 1'b1;
    tick();
    bus.iniciar = 1'b0;
    tick();
    n_tests++;
    if (bus.etapa !== 2'd2) begin
      n_fail++; $display("FAIL abort_setup etapa got %h exp 2", bus.etapa);
    end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    n_tests++;
    if ({bus.barramento, bus.etapa} !== {8'h00, 2'd0}) begin
      n_fail++; $display("FAIL abort_x x/etapa got %h/%h exp 00/0", bus.barramento, bus.etapa);
    end
    run_prog(100, 1'b0, h);
    n_tests++;
    if ({h[7:0], bus.barramento} !== {8'd6, 8'h77}) begin
      n_fail++; $display("FAIL after_abort halt/x got %0d/%h exp 6/77", h, bus.barramento);
    end
  endtask

  task automatic test_wrap();
    int h;
    for (int a = 0; a < 15; a++) load(a, 4'h0, 8'h00);
    load(15, 4'hB, 8'h05);
    run_prog(60, 1'b0, h);
    exp_q.delete();
    for (int a = 0; a < 16; a++) exp_q.push_back(4'(a));
    for (int a = 5; a < 9; a++) exp_q.push_back(4'(a));
    n_tests++;
    if (h !== -1 || fetch_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL wrap_jmp halt %0d fetches %0d exp -1 and %0d", h, fetch_q.size(), exp_q.size());
    end else begin
      for (int i = 14; i < exp_q.size(); i++) begin
        n_tests++;
        if (fetch_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL wrap_jmp_fetch%0d got %h exp %h", i, fetch_q[i], exp_q[i]);
        end
      end
    end
    do_reset();
    load(15, 4'h0, 8'h00);
    run_prog(54, 1'b0, h);
    n_tests++;
    if (h !== -1 || fetch_q.size() !== 18) begin
      n_fail++; $display("FAIL wrap_nop halt %0d fetches %0d exp -1 and 18", h, fetch_q.size());
    end else begin
      n_tests++;
      if ({fetch_q[15], fetch_q[16], fetch_q[17]} !== {4'd15, 4'd0, 4'd1}) begin
        n_fail++; $display("FAIL wrap_nop_seq got %h %h %h exp f 0 1", fetch_q[15], fetch_q[16], fetch_q[17]);
      end
    end
    do_reset();
  endtask

  initial begin
    bus.entrada   = '0;
    bus.iniciar   = 1'b0;
    bus.prog_we   = 1'b0;
    bus.prog_addr = '0;
    bus.prog_dado = '0;
    test_reset();
    test_add_output();
    test_overflow();
    test_logic();
    test_back_to_back();
    test_loop();
    test_protection();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
